tp_pingpong_buf: RTL and testbench

//  Parametrised ping-pong transpose buffer for the 2-D DCT datapath. It replaces a flag-steered pair of

---
 rtl/dct_pkg.sv | 7 +
 rtl/tp_bank.sv | 23 ++
 rtl/tp_pingpong_buf.sv | 82 ++++++++
 tb/tb_tp_pingpong_buf.sv | 135 +++++++++++++
 4 files changed

// File: rtl/dct_pkg.sv
// dct_pkg: shared types and constants for the 2-D DCT datapath.
package dct_pkg;
  typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_state_e;
  localparam int DCT_N  = 16;
  localparam int ROW_DW = 11;
  localparam int COL_DW = 12;
endpackage

// File: rtl/tp_bank.sv
// tp_bank: NxN register array with a row write port and a combinational
// column-or-row read port selected by the bank's mode bit.
module tp_bank #(
  parameter int N  = 16,
  parameter int DW = 11
) (
  input  logic                 clk,
  input  logic                 we_i,
  input  logic [$clog2(N)-1:0] waddr_i,
  input  logic [N*DW-1:0]      wdata_i,
  input  logic                 tp_i,
  input  logic [$clog2(N)-1:0] raddr_i,
  output logic [N*DW-1:0]      rdata_o
);
  logic [N*DW-1:0] mem_q [N];
  logic [N*DW-1:0] col;
  always_ff @(posedge clk)
    if (we_i) mem_q[waddr_i] <= wdata_i;
  for (genvar k = 0; k < N; k++) begin : g_col
    assign col[k*DW +: DW] = mem_q[k][DW*int'(raddr_i) +: DW];
  end
  assign rdata_o = tp_i ? col : mem_q[raddr_i];
endmodule

// File: rtl/tp_pingpong_buf.sv
// tp_pingpong_buf: ping-pong NxN transpose buffer; one bank fills by rows
// while the other drains by columns (or rows in bypass mode).
module tp_pingpong_buf
  import dct_pkg::*;
#(
  parameter int N  = DCT_N,
  parameter int DW = ROW_DW
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          clr,
  input  logic          tp_en,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N*DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N*DW-1:0] out_data,
  output logic          out_last
);
  localparam int AW = $clog2(N);
  localparam logic [AW-1:0] LAST = AW'(N - 1);
  bank_state_e state_q [2];
  bank_state_e state_d [2];
  logic            wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic [AW-1:0]   wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  logic [1:0]      mode_q, mode_d;
  logic [N*DW-1:0] rdata [2];
  logic            wr_acc, rd_acc, wr_done, rd_done;
  assign in_ready  = state_q[wr_bank_q] inside {EMPTY, FILLING};
  assign out_valid = state_q[rd_bank_q] inside {FULL, DRAINING};
  assign out_last  = out_valid & (rd_cnt_q == LAST);
  assign out_data  = out_valid ? rdata[rd_bank_q] : '0;
  // clr suppresses both handshakes so no bank state or storage moves
  assign wr_acc  = in_valid & in_ready & ~clr;
  assign rd_acc  = out_valid & out_ready & ~clr;
  assign wr_done = wr_acc & (wr_cnt_q == LAST);
  assign rd_done = rd_acc & (rd_cnt_q == LAST);
  always_comb begin
    wr_bank_d = clr ? 1'b0 : wr_bank_q ^ wr_done;
    rd_bank_d = clr ? 1'b0 : rd_bank_q ^ rd_done;
    wr_cnt_d  = (clr | wr_done) ? '0 : wr_cnt_q + AW'(wr_acc);
    rd_cnt_d  = (clr | rd_done) ? '0 : rd_cnt_q + AW'(rd_acc);
    mode_d    = mode_q;
    if (wr_acc && wr_cnt_q == '0) mode_d[wr_bank_q] = tp_en;
    for (int b = 0; b < 2; b++) begin
      state_d[b] = state_q[b];
      if (wr_acc && wr_bank_q == 1'(b)) state_d[b] = wr_done ? FULL : FILLING;
      if (rd_acc && rd_bank_q == 1'(b)) state_d[b] = rd_done ? EMPTY : DRAINING;
      if (clr) state_d[b] = EMPTY;
    end
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q[0] <= EMPTY;
      state_q[1] <= EMPTY;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      mode_q     <= '0;
    end else begin
      state_q    <= state_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      mode_q     <= mode_d;
    end
  end
  for (genvar g = 0; g < 2; g++) begin : g_bank
    tp_bank #(.N(N), .DW(DW)) u_bank (
      .clk     (clk),
      .we_i    (wr_acc & (wr_bank_q == 1'(g))),
      .waddr_i (wr_cnt_q),
      .wdata_i (in_data),
      .tp_i    (mode_q[g]),
      .raddr_i (rd_cnt_q),
      .rdata_o (rdata[g])
    );
  end
endmodule

// File: tb/tb_tp_pingpong_buf.sv
// tb_tp_pingpong_buf: directed + random stimulus checked against a queue-based
// model of whole blocks (rows in, pre-computed output beats out).
module tb_tp_pingpong_buf;
  localparam int N  = 16;
  localparam int DW = 11;
  typedef struct { logic [N*DW-1:0] d; bit last; } beat_t;
  logic clk = 0, rstn = 0, clr = 0, tp_en = 0, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid, out_last;
  logic [N*DW-1:0] in_data = '0, out_data;
  int ncmp = 0, nfail = 0;
  logic [N*DW-1:0] rowbuf [N];
  beat_t expq [$];
  int wr_row = 0, nfull = 0;
  bit blk_mode = 0;
  tp_pingpong_buf #(.N(N), .DW(DW)) dut (
    .clk(clk), .rstn(rstn), .clr(clr), .tp_en(tp_en),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last)
  );
  always #5 clk = ~clk;
  task automatic cmp(input string tag, input logic [N*DW-1:0] obs, input logic [N*DW-1:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    expq.delete();
    wr_row = 0;
    nfull = 0;
  endtask
  task automatic check_outputs();
    cmp("in_ready", in_ready, nfull < 2);
    cmp("out_valid", out_valid, nfull > 0);
    if (nfull > 0) begin
      cmp("out_data", out_data, expq[0].d);
      cmp("out_last", out_last, expq[0].last);
    end else begin
      cmp("out_data_idle", out_data, '0);
      cmp("out_last_idle", out_last, 1'b0);
    end
  endtask
  // one cycle: check at negedge, drive, advance model on the posedge
  task automatic step(input bit iv, input bit orr, input bit tp, input bit c, input bit pat);
    bit wacc, racc;
    beat_t bt;
    check_outputs();
    in_valid = iv; out_ready = orr; tp_en = tp; clr = c;
    for (int i = 0; i < N; i++)
      in_data[i*DW +: DW] = pat ? DW'(wr_row * N + i) : DW'($urandom);
    wacc = iv && nfull < 2;
    racc = orr && nfull > 0;
    @(posedge clk);
    if (c) model_reset();
    else begin
      if (racc) begin
        bt = expq.pop_front();
        if (bt.last) nfull--;
      end
      if (wacc) begin
        if (wr_row == 0) blk_mode = tp;
        rowbuf[wr_row] = in_data;
        if (wr_row == N - 1) begin
          for (int b = 0; b < N; b++) begin
            for (int k = 0; k < N; k++)
              bt.d[k*DW +: DW] = blk_mode ? rowbuf[k][b*DW +: DW] : rowbuf[b][k*DW +: DW];
            bt.last = (b == N - 1);
            expq.push_back(bt);
          end
          nfull++;
          wr_row = 0;
        end else wr_row++;
      end
    end
    @(negedge clk);
    in_valid = 0; out_ready = 0; clr = 0;
  endtask
  initial begin
    logic [N*DW-1:0] exp0;
    @(negedge clk);
    cmp("rst_in_ready", in_ready, 1'b1);
    cmp("rst_out_valid", out_valid, 1'b0);
    cmp("rst_out_data", out_data, '0);
    rstn = 1;
    // 1: single transposed block with known element values
    for (int i = 0; i < N; i++) step(1, 1, 1, 0, 1);
    for (int k = 0; k < N; k++) exp0[k*DW +: DW] = DW'(k * N);
    cmp("t1_first_beat", out_data, exp0);
    for (int i = 0; i < N + 4; i++) step(0, 1, 1, 0, 0);
    // 2: three blocks back-to-back
    for (int i = 0; i < 3 * N; i++) step(1, 1, 1, 0, 0);
    for (int i = 0; i < N + 4; i++) step(0, 1, 1, 0, 0);
    // 3: backpressure fills both banks, single-beat release
    for (int i = 0; i < 2 * N + 6; i++) step(1, 0, 1, 0, 0);
    step(1, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 0);
    for (int i = 0; i < 3 * N; i++) step(i < N, 1, 1, 0, 0);
    // 4: bypass block then transposed block with tp_en toggling mid-block
    for (int i = 0; i < N; i++) step(1, 1, 0, 0, 1);
    for (int i = 0; i < N; i++) step(1, 1, (i % 2) == 0, 0, 1);
    for (int i = 0; i < N + 4; i++) step(0, 1, 0, 0, 0);
    // 5: async reset partway through a block
    for (int i = 0; i < 8; i++) step(1, 0, 1, 0, 1);
    rstn = 0;
    #1;
    cmp("t5_in_ready", in_ready, 1'b1);
    cmp("t5_out_valid", out_valid, 1'b0);
    cmp("t5_out_last", out_last, 1'b0);
    cmp("t5_out_data", out_data, '0);
    @(posedge clk);
    @(negedge clk);
    rstn = 1;
    model_reset();
    for (int i = 0; i < N; i++) step(1, 1, 1, 0, 0);
    for (int i = 0; i < N + 4; i++) step(0, 1, 1, 0, 0);
    // 6: clr with bank 0 at beat 5 and bank 1 at row 3
    for (int i = 0; i < N; i++) step(1, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 1, 0, 0);
    for (int i = 0; i < 2; i++) step(0, 1, 1, 0, 0);
    step(1, 1, 1, 1, 0);
    cmp("t6_in_ready", in_ready, 1'b1);
    cmp("t6_out_valid", out_valid, 1'b0);
    for (int i = 0; i < N; i++) step(1, 1, 1, 0, 1);
    for (int i = 0; i < N + 4; i++) step(0, 1, 1, 0, 0);
    // random soak
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, 0, 0);
    for (int i = 0; i < 2 * N + 4; i++) step(0, 1, 0, 0, 0);
    check_outputs();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
